// File: rtl/arb_pkg.sv
// Shared arbitration types and defaults: FSM state encoding, default hold
// quantum, and a one-hot helper used by the 4-way channel arbiters.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int QUANTUM_DEFAULT = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search over a 4-bit request mask: the first set bit
// found walking start, start+1, start+2, start+3 (mod 4) wins.
module rr_pick4 (
  input  logic [3:0] mask,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    pos   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      pos = start + 2'(k);
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/arb4_sched.sv
// Four-requester round-robin arbiter for a shared 1-bit channel, with a hold
// quantum that forces hand-off only while another requester is waiting.
module arb4_sched
  import arb_pkg::*;
#(
  parameter int QUANTUM = QUANTUM_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] grant,
  output logic [1:0] S,
  output logic       out,
  output logic       valid,
  output arb_state_e dbg_state
);

  localparam logic [3:0] CNT_LAST = 4'(QUANTUM - 1);

  arb_state_e state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] pick_mask;
  logic [1:0] pick_start;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       own_req;

  // Idle: search the full mask from ptr. Busy: search the others from owner+1.
  always_comb begin
    if (state_q == IDLE) begin
      pick_mask  = req;
      pick_start = ptr_q;
    end else begin
      pick_mask  = req & ~onehot4(sel_q);
      pick_start = sel_q + 2'd1;
    end
  end

  rr_pick4 u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req = req[sel_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = onehot4(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        if (own_req && cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (own_req && !pick_found) begin
          // Quantum expired with nobody waiting: start a fresh window.
          cnt_d = 4'd0;
        end else begin
          ptr_d = sel_q + 2'd1;
          cnt_d = 4'd0;
          if (pick_found) begin
            grant_d = onehot4(pick_idx);
            sel_d   = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign S         = sel_q;
  assign valid     = (state_q == BUSY);
  assign dbg_state = state_q;

  always_comb begin
    out = 1'b0;
    if (valid) begin
      case (sel_q)
        2'd0:    out = a;
        2'd1:    out = b;
        2'd2:    out = c;
        default: out = d;
      endcase
    end
  end

endmodule

// File: tb/tb_arb4_sched.sv
// Bench for arb4_sched: directed scenarios plus random traffic, all checked
// against an owner/hold-count model of the arbitration rules.
module tb_arb4_sched;
  import arb_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [3:0] grant;
  logic [1:0] S;
  logic       out;
  logic       valid;
  arb_state_e dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // Model: current owner (-1 = none), cycles held so far, priority start, last select.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  arb4_sched #(.QUANTUM(Q)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .grant     (grant),
    .S         (S),
    .out       (out),
    .valid     (valid),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] m, input int start);
    for (int k = 0; k < 4; k++) begin
      if (m[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [3:0] others;
    int w;
    if (reset) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = search(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      w = search(others, (m_owner + 1) % 4);
      if (req[m_owner] && (m_hold < Q || w < 0)) begin
        m_hold = (m_hold < Q) ? m_hold + 1 : 1;
      end else begin
        m_ptr = (m_owner + 1) % 4;
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_hold = 1;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] dvec;
    logic [3:0] exp_grant;
    logic       exp_valid;
    dvec      = {d, c, b, a};
    exp_valid = (m_owner >= 0);
    exp_grant = exp_valid ? 4'(1 << m_owner) : 4'b0000;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("sel", 32'(S), 32'(m_sel));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("out", 32'(out), exp_valid ? 32'(dvec[m_sel]) : 32'd0);
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    chk("state", 32'(dbg_state == BUSY), 32'(exp_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(S), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    tick();
    chk("idle_grant", 32'(grant), 32'd0);

    // Single requester 2 with data follow-through
    req = 4'b0100; c = 1'b1;
    tick();
    chk("r2_grant", 32'(grant), 32'h4);
    chk("r2_sel", 32'(S), 32'd2);
    chk("r2_valid", 32'(valid), 32'd1);
    chk("r2_out", 32'(out), 32'd1);
    c = 1'b0; #1;
    chk("r2_out_low", 32'(out), 32'd0);
    c = 1'b1; #1;
    chk("r2_out_high", 32'(out), 32'd1);
    req = 4'b0000;
    tick();
    chk("r2_rel", 32'(grant), 32'd0);

    // Full contention rotates 0,1,2,3,0 with Q cycles each
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5 * Q; k++) begin
      tick();
      chk("rot", 32'(grant), 32'(1 << ((k / Q) % 4)));
    end

    // Lone requester is never pre-empted
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("lone", 32'(grant), 32'h1);
    end

    // Owner 3 drops with requester 0 pending: wrap hand-off
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1001;
    tick();
    chk("own3", 32'(grant), 32'h8);
    req = 4'b0001;
    tick();
    chk("wrap_grant", 32'(grant), 32'h1);
    chk("wrap_sel", 32'(S), 32'd0);

    // Owner 1 drops with nobody else: release to idle, S holds
    do_reset();
    b = 1'b1;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    chk("rel_grant", 32'(grant), 32'd0);
    chk("rel_valid", 32'(valid), 32'd0);
    chk("rel_out", 32'(out), 32'd0);
    chk("rel_sel", 32'(S), 32'd1);

    // Reset mid-grant under full contention
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 2 * Q + 1; k++) tick();
    chk("pre_rst_grant", 32'(grant), 32'h4);
    reset = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_sel", 32'(S), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'h1);

    // Random traffic: sticky request bits, random data, occasional reset
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      end
      a = 1'($urandom); b = 1'($urandom); c = 1'($urandom); d = 1'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/arb4_sched.md
ARB4_SCHED -- requirements
Module: arb4_sched

Interface
REQ-001 Parameter QUANTUM, default 8, maximum consecutive grant cycles per owner while another requester waits; legal range 2..15.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only on rising edge of clk.
REQ-004 req  input  4  request lines; bit i = requester i (0..3) wants the shared 1-bit channel.
REQ-005 a, b, c, d  input  1 each  data bit of requester 0, 1, 2, 3 respectively.
REQ-006 grant  output  4  registered one-hot grant; all-zero when channel idle.
REQ-007 S  output  2  registered select code of current owner (0..3); drives the shared 4:1 selector.
REQ-008 out  output  1  shared channel output: data bit of owner while valid=1, else 0.
REQ-009 valid  output  1  registered; 1 exactly when grant is non-zero.

Function
REQ-010 FSM has two states, IDLE and BUSY; valid=1 iff state is BUSY.
REQ-011 Round-robin pointer ptr (2 bits) names the highest-priority requester; priority order is ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-012 IDLE with req==0: stay IDLE; grant, S, valid unchanged at reset values.
REQ-013 IDLE with any req bit set: next cycle enter BUSY, grant the winner per REQ-011, S = winner index, hold counter = 0.
REQ-014 Grant latency from req assertion on an idle channel is exactly one clock.
REQ-015 BUSY, owner's req still 1, hold counter < QUANTUM-1: keep owner, increment counter.
REQ-016 BUSY, owner's req still 1, counter == QUANTUM-1, no other req bit set: keep owner, counter returns to 0 (no forced release without contention).
REQ-017 BUSY, owner's req still 1, counter == QUANTUM-1, another req bit set: pre-empt; next cycle grant the winner among the other requesters searched from owner+1, counter = 0.
REQ-018 BUSY, owner's req drops to 0, another req bit set: next cycle grant the winner searched from owner+1 (no idle gap), counter = 0.
REQ-019 BUSY, owner's req drops to 0, no other req bit set: next cycle return to IDLE, grant = 0, valid = 0, S holds last owner.
REQ-020 On every owner change or release, ptr = (previous owner + 1) modulo 4, including wrap 3 -> 0.
REQ-021 Owner dropping req and re-asserting in the same cycle is not visible; a one-cycle req low is a release.
REQ-022 out is combinational from S, valid and a..d: S=0 -> a, 1 -> b, 2 -> c, 3 -> d, gated to 0 when valid=0; no added latency.
REQ-023 grant is always one-hot or zero; never more than one bit set in any cycle.
REQ-024 Hold counter is 4 bits, saturates never (bounded by REQ-015..017), undefined values not permitted.

Reset
REQ-025 reset=1 at a rising edge: state = IDLE, grant = 4'b0000, S = 2'b00, valid = 0, ptr = 0, counter = 0.
REQ-026 reset has priority over all other inputs, including mid-grant; the current owner is dropped without handoff.
REQ-027 First arbitration after reset release uses ptr = 0 (requester 0 highest).

Structure
REQ-028 State encodings (IDLE=0, BUSY=1) and the QUANTUM default belong in the shared package arb_pkg for reuse by other controllers.
REQ-029 Rotating priority search shall be one combinational sub-module rr_pick4 (inputs: 4-bit request mask, 2-bit start index; outputs: found flag, 2-bit winner index).
REQ-030 The top instantiates rr_pick4 once; pre-emption/handoff searches pass the request mask with the owner bit cleared.

Verification
REQ-031 reset pulse during BUSY with req=4'b1111 -> next cycle grant=0000, valid=0, S=0; after release, first grant goes to requester 0.
REQ-032 req=0100 from IDLE, c=1 -> one cycle later grant=0100, S=2, valid=1, out=1; c toggled -> out follows same cycle.
REQ-033 req=1111 held, QUANTUM=8 -> grants rotate 0,1,2,3,0 each held exactly 8 cycles, no idle gap.
REQ-034 req=0001 held 20 cycles, no other requester -> grant stays 0001 for all 20 cycles (no pre-emption).
REQ-035 owner 3 drops req while req=0001 pending -> next cycle grant=0001, S=0 (wrap 3 -> 0).
REQ-036 owner 1 drops req, no other req -> next cycle grant=0000, valid=0, out=0, S=1; every cycle of every test checks grant one-hot-or-zero.
